// File: rtl/ooo_pkg.sv
// Shared out-of-order core definitions for the issue stage.
// Contents:
//   PREG_W / ROB_W : physical register tag and ROB number widths
//   aluop_e, fu_e  : ALU operation and functional-unit class encodings
//   rs_entry_t     : one reservation-station slot
//                    {valid, sr1_p, s1_rdy, sr2_p, s2_rdy, dr_p, aluop, fu, imm, rob}
package ooo_pkg;

  localparam int PREG_W = 5;
  localparam int ROB_W  = 16;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_AND = 2'd2,
    ALU_OR  = 2'd3
  } aluop_e;

  typedef enum logic [1:0] {
    FU_ALU = 2'd0,
    FU_MUL = 2'd1,
    FU_LSU = 2'd2,
    FU_BR  = 2'd3
  } fu_e;

  typedef struct packed {
    logic              valid;
    logic [PREG_W-1:0] sr1_p;
    logic              s1_rdy;
    logic [PREG_W-1:0] sr2_p;
    logic              s2_rdy;
    logic [PREG_W-1:0] dr_p;
    aluop_e            aluop;
    fu_e               fu;
    logic [31:0]       imm;
    logic [ROB_W-1:0]  rob;
  } rs_entry_t;

endpackage

// File: rtl/rs_prio_enc.sv
// Lowest-index-set priority encoder.
// Ports:
//   req_i   : request vector, bit 0 has highest priority
//   found_o : at least one request bit is set
//   idx_o   : index of the lowest set bit (0 when found_o=0)
module rs_prio_enc #(
  parameter  int N  = 16,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  output logic          found_o,
  output logic [IW-1:0] idx_o
);

  // Scan from the top down so the last hit written is the lowest index.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        found_o = 1'b1;
        idx_o   = IW'(i);
      end
    end
  end

endmodule

// File: rtl/reservation_station.sv
// Unified issue queue between rename and execute. Holds renamed uops until
// both source operands are ready, snoops writeback tag broadcasts for wakeup,
// and issues at most one ready uop per cycle (lowest index first).
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   flush             : synchronous clear of all entries
//   in_valid/in_ready : rename -> RS handshake, in_* uop fields
//   wb_valid/wb_tag   : writeback broadcasts, port 0 in the tag LSBs
//   iss_valid/iss_ready : RS -> execute handshake, iss_* uop fields
//   count             : registered occupancy
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both 1; valid never depends on ready on the same interface.
module reservation_station
  import ooo_pkg::*;
#(
  parameter  int DEPTH    = 16,
  parameter  int WB_PORTS = 2,
  localparam int IW       = $clog2(DEPTH),
  localparam int CW       = $clog2(DEPTH) + 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [PREG_W-1:0]          in_sr1_p,
  input  logic [PREG_W-1:0]          in_sr2_p,
  input  logic                       in_s1_ready,
  input  logic                       in_s2_ready,
  input  logic [PREG_W-1:0]          in_dr_p,
  input  logic [1:0]                 in_aluop,
  input  logic [1:0]                 in_fu,
  input  logic [31:0]                in_imm,
  input  logic [ROB_W-1:0]           in_rob,
  input  logic [WB_PORTS-1:0]        wb_valid,
  input  logic [WB_PORTS*PREG_W-1:0] wb_tag,
  output logic                       iss_valid,
  input  logic                       iss_ready,
  output logic [PREG_W-1:0]          iss_sr1_p,
  output logic [PREG_W-1:0]          iss_sr2_p,
  output logic [PREG_W-1:0]          iss_dr_p,
  output logic [1:0]                 iss_aluop,
  output logic [1:0]                 iss_fu,
  output logic [31:0]                iss_imm,
  output logic [ROB_W-1:0]           iss_rob,
  output logic [CW-1:0]              count
);

  rs_entry_t ent_q [DEPTH];
  rs_entry_t ent_d [DEPTH];
  logic [CW-1:0] count_q, count_d;

  logic [DEPTH-1:0]                valid_vec, cand_vec;
  logic [DEPTH-1:0][WB_PORTS-1:0]  s1_hit, s2_hit;
  logic [WB_PORTS-1:0]             in1_hit, in2_hit;
  logic                            free_found;
  logic [IW-1:0]                   free_idx, sel_idx;
  logic                            accept, issue;

  // Per-entry, per-port wakeup comparators.
  for (genvar e = 0; e < DEPTH; e++) begin : g_ent
    assign valid_vec[e] = ent_q[e].valid;
    assign cand_vec[e]  = ent_q[e].valid && ent_q[e].s1_rdy && ent_q[e].s2_rdy;
    for (genvar k = 0; k < WB_PORTS; k++) begin : g_wb
      assign s1_hit[e][k] = wb_valid[k] && (wb_tag[k*PREG_W +: PREG_W] == ent_q[e].sr1_p);
      assign s2_hit[e][k] = wb_valid[k] && (wb_tag[k*PREG_W +: PREG_W] == ent_q[e].sr2_p);
    end
  end

  // Same-cycle bypass for the incoming uop so a broadcast during allocation
  // is not lost.
  for (genvar k = 0; k < WB_PORTS; k++) begin : g_in_wb
    assign in1_hit[k] = wb_valid[k] && (wb_tag[k*PREG_W +: PREG_W] == in_sr1_p);
    assign in2_hit[k] = wb_valid[k] && (wb_tag[k*PREG_W +: PREG_W] == in_sr2_p);
  end

  rs_prio_enc #(.N(DEPTH)) u_free (
    .req_i   (~valid_vec),
    .found_o (free_found),
    .idx_o   (free_idx)
  );

  rs_prio_enc #(.N(DEPTH)) u_sel (
    .req_i   (cand_vec),
    .found_o (iss_valid),
    .idx_o   (sel_idx)
  );

  assign in_ready = (count_q != CW'(DEPTH));
  assign accept   = in_valid && in_ready && free_found;
  assign issue    = iss_valid && iss_ready;

  // The free slot is chosen from the registered valid bits, so it can never
  // be the slot that is issuing in the same cycle.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_d[i] = ent_q[i];
      if (ent_q[i].valid) begin
        ent_d[i].s1_rdy = ent_q[i].s1_rdy | (|s1_hit[i]);
        ent_d[i].s2_rdy = ent_q[i].s2_rdy | (|s2_hit[i]);
      end
    end
    if (issue) begin
      ent_d[sel_idx].valid = 1'b0;
    end
    if (accept) begin
      ent_d[free_idx].valid  = 1'b1;
      ent_d[free_idx].sr1_p  = in_sr1_p;
      ent_d[free_idx].s1_rdy = in_s1_ready || (in_sr1_p == '0) || (|in1_hit);
      ent_d[free_idx].sr2_p  = in_sr2_p;
      ent_d[free_idx].s2_rdy = in_s2_ready || (in_sr2_p == '0) || (|in2_hit);
      ent_d[free_idx].dr_p   = in_dr_p;
      ent_d[free_idx].aluop  = aluop_e'(in_aluop);
      ent_d[free_idx].fu     = fu_e'(in_fu);
      ent_d[free_idx].imm    = in_imm;
      ent_d[free_idx].rob    = in_rob;
    end
    count_d = count_q + CW'(accept) - CW'(issue);
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_d[i].valid = 1'b0;
      end
      count_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '0;
      end
      count_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= ent_d[i];
      end
      count_q <= count_d;
    end
  end

  assign iss_sr1_p = ent_q[sel_idx].sr1_p;
  assign iss_sr2_p = ent_q[sel_idx].sr2_p;
  assign iss_dr_p  = ent_q[sel_idx].dr_p;
  assign iss_aluop = ent_q[sel_idx].aluop;
  assign iss_fu    = ent_q[sel_idx].fu;
  assign iss_imm   = ent_q[sel_idx].imm;
  assign iss_rob   = ent_q[sel_idx].rob;
  assign count     = count_q;

endmodule
